// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   XLEN / ILEN      : PC width and instruction width
//   HALT_WORD        : instruction word that stops fetching
//   QENTRY_W         : width of one fetch-queue entry ({pc, word})
//   fetch_state_e    : fetch controller states
//   fetch_entry_t    : packed queue entry
//   align_pc()       : clears the byte-offset bits of a PC
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN     = 64;
  localparam int ILEN     = 32;
  localparam int QENTRY_W = XLEN + ILEN;

  localparam logic [ILEN-1:0] HALT_WORD = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] word;
  } fetch_entry_t;

  // Instructions are word aligned; any low byte-offset bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Two-entry FIFO holding fetched {pc, word} entries between the instruction
// memory and the memory-access stage.
// Ports:
//   clk      : clock, all state on rising edge
//   rst_ni   : asynchronous active-low reset, empties the queue
//   push_i   : write data_i at the tail (ignored when full without a pop)
//   pop_i    : drop the head entry (ignored when empty)
//   flush_i  : discard all entries; dominates push and pop
//   data_i   : entry to push
//   data_o   : head entry (meaningful only when !empty_o)
//   full_o   : both slots occupied
//   empty_o  : no slot occupied
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int W = QENTRY_W
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] slot_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q,  count_d;
  logic         push_ok;
  logic         pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign data_o  = slot_q[rd_ptr_q];

  // A push into a full queue is legal only when the head leaves in the
  // same cycle, which frees the slot being overwritten.
  assign pop_ok  = pop_i  && !empty_o && !flush_i;
  assign push_ok = push_i && !flush_i && (!full_o || pop_ok);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) slot_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
// Fetches 32-bit instructions from a loadable instruction memory and presents
// them, with their byte PC, to the memory-access stage through a 2-entry queue.
// Fetching stops on the halt word and restarts on a redirect.
// Ports:
//   clk          : clock, all state on rising edge
//   rst          : asynchronous active-low reset
//   load_en      : write load_data to instruction memory at load_addr
//   load_addr    : word address of the load
//   load_data    : instruction word to store
//   redirect_en  : flush the queue and restart fetching at redirect_pc
//   redirect_pc  : new byte PC (low two bits ignored)
//   ready        : downstream accepts the head instruction this cycle
//   I            : head instruction (0 when !valid)
//   pc_out       : byte PC of I (0 when !valid)
//   valid        : I / pc_out carry a real instruction
//   halted       : fetch stopped on the halt word
// -----------------------------------------------------------------------------
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int              MEM_WORDS = 64,
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [ILEN-1:0]              load_data,
  input  logic                         redirect_en,
  input  logic [XLEN-1:0]              redirect_pc,
  input  logic                         ready,
  output logic [ILEN-1:0]              I,
  output logic [XLEN-1:0]              pc_out,
  output logic                         valid,
  output logic                         halted
);

  localparam int AW = $clog2(MEM_WORDS);

  fetch_state_e    state_q,  state_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic            halted_q, halted_d;

  logic [ILEN-1:0] imem_q [MEM_WORDS];
  logic [AW-1:0]   fetch_idx;
  logic [ILEN-1:0] fetch_word;
  logic            fetch_is_halt;
  logic            fetch_en;

  fetch_entry_t    q_push_data;
  fetch_entry_t    q_head;
  logic            q_push;
  logic            q_pop;
  logic            q_full;
  logic            q_empty;

  // ---------------------------------------------------------------------------
  // Instruction memory. Loads are plain synchronous writes and are not
  // affected by reset, so a program survives a reset pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_en) imem_q[load_addr] <= load_data;
  end

  // Upper PC bits are ignored, so the fetch address wraps around the memory.
  assign fetch_idx     = pc_q[AW+1:2];
  assign fetch_word    = imem_q[fetch_idx];
  assign fetch_is_halt = (fetch_word == HALT_WORD);

  // ---------------------------------------------------------------------------
  // Fetch decision. The queue slot written at the fetch edge acts as the
  // memory's read register, giving one cycle from fetch to valid output.
  // Because the write port uses a non-blocking update, a fetch that coincides
  // with a load of the same word captures the old contents.
  // ---------------------------------------------------------------------------
  assign q_pop    = valid && ready;
  assign fetch_en = (state_q == ST_RUN) && !redirect_en && (!q_full || q_pop);

  // The halt word itself never enters the queue.
  assign q_push           = fetch_en && !fetch_is_halt;
  assign q_push_data.pc   = pc_q;
  assign q_push_data.word = fetch_word;

  fetch_queue #(
    .W (QENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst_ni  (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (redirect_en),
    .data_i  (q_push_data),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // ---------------------------------------------------------------------------
  // Fetch controller. Redirect overrides every other transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    if (redirect_en) begin
      state_d  = ST_RUN;
      pc_d     = align_pc(redirect_pc);
      halted_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (fetch_en) begin
            if (fetch_is_halt) begin
              // PC stays on the halt word.
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = pc_q + XLEN'(4);
            end
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d  = ST_IDLE;
          halted_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The head is held in the queue until accepted, so I / pc_out stay
  // stable while valid && !ready; they read as zero when nothing is queued.
  // ---------------------------------------------------------------------------
  assign valid  = !q_empty;
  assign I      = valid ? q_head.word : '0;
  assign pc_out = valid ? q_head.pc   : '0;
  assign halted = halted_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
// Directed scenarios followed by a randomized stretch, all compared against a
// queue-based behavioural model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

  localparam int MW = 64;
  localparam int AW = 6;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] w;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          redirect_en;
  logic [63:0]   redirect_pc;
  logic          ready;
  logic [31:0]   I;
  logic [63:0]   pc_out;
  logic          valid;
  logic          halted;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  logic [31:0] prog [5] = '{32'hFE532A23, 32'hFF433383, 32'h0063A023,
                            32'h0003B403, 32'h00000000};

  // Behavioural model state
  logic [31:0] mem_m [MW];
  ent_t        q_m [$];
  logic [63:0] pc_m;
  bit          started_m;
  bit          halted_m;

  instr_fetch_stage #(
    .MEM_WORDS (MW),
    .RESET_PC  (64'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .ready       (ready),
    .I           (I),
    .pc_out      (pc_out),
    .valid       (valid),
    .halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, name, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q_m.delete();
    pc_m      = 64'h0;
    started_m = 1'b0;
    halted_m  = 1'b0;
  endfunction

  // One rising edge of the model, using the currently driven inputs.
  task automatic model_edge();
    ent_t        e;
    logic [31:0] w;
    bit          pop;
    bit          can;
    if (rst) begin
      if (redirect_en) begin
        q_m.delete();
        pc_m      = redirect_pc & ~64'h3;
        started_m = 1'b1;
        halted_m  = 1'b0;
      end else if (!started_m) begin
        started_m = 1'b1;
      end else begin
        pop = (q_m.size() > 0) && ready;
        can = !halted_m && ((q_m.size() < 2) || pop);
        if (pop) void'(q_m.pop_front());
        if (can) begin
          w = mem_m[int'((pc_m >> 2) % MW)];
          if (w == 32'h0) begin
            halted_m = 1'b1;
          end else begin
            e.pc = pc_m;
            e.w  = w;
            q_m.push_back(e);
            pc_m = pc_m + 64'd4;
          end
        end
      end
    end
    // Memory write lands after the fetch read: same-word fetch sees old data.
    if (load_en) mem_m[load_addr] = load_data;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_i;
    logic [63:0] exp_pc;
    bit          exp_v;
    exp_v  = (q_m.size() > 0);
    exp_i  = 32'h0;
    exp_pc = 64'h0;
    if (exp_v) begin
      exp_i  = q_m[0].w;
      exp_pc = q_m[0].pc;
    end
    check("valid",  64'(valid),  64'(exp_v));
    check("I",      64'(I),      64'(exp_i));
    check("pc_out", pc_out,      exp_pc);
    check("halted", 64'(halted), 64'(halted_m));
  endtask

  // Called at a falling edge: check, advance model, cross one rising edge.
  task automatic tick();
    check_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = 32'h0;
    redirect_en = 1'b0;
    redirect_pc = 64'h0;
  endtask

  // Asserts reset between clock edges and leaves it asserted for one edge.
  task automatic async_reset();
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_valid_now", 64'(valid), 64'(1'b0));
    @(negedge clk);
    tick();
  endtask

  initial begin
    idle_inputs();
    ready = 1'b0;
    rst   = 1'b0;
    model_reset();
    for (int k = 0; k < MW; k++) mem_m[k] = 32'h0;
    #1;

    // ---------------- reset state + program load ----------------
    phase = "reset";
    check("rst_valid",  64'(valid),  64'h0);
    check("rst_I",      64'(I),      64'h0);
    check("rst_pc_out", pc_out,      64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    @(negedge clk);
    for (int k = 0; k < MW; k++) begin
      load_en   = 1'b1;
      load_addr = AW'(k);
      load_data = (k < 5) ? prog[k] : ($urandom() | 32'h1);
      tick();
    end
    idle_inputs();

    // ---------------- straight-line run to halt ----------------
    phase = "run";
    rst   = 1'b1;
    ready = 1'b1;
    tick();
    check("first_edge_valid", 64'(valid), 64'h0);
    tick();
    check("first_I",  64'(I), 64'hFE532A23);
    check("first_pc", pc_out, 64'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("seq_I",  64'(I), 64'(prog[k]));
      check("seq_pc", pc_out, 64'(4 * k));
    end
    tick();
    check("halt_valid",  64'(valid),  64'h0);
    check("halt_halted", 64'(halted), 64'h1);

    // ---------------- backpressure ----------------
    phase = "stall";
    async_reset();
    rst   = 1'b1;
    ready = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_I",  64'(I), 64'hFE532A23);
      check("stall_pc", pc_out, 64'h0);
    end
    ready = 1'b1;
    begin
      int got;
      got = 0;
      for (int k = 0; k < 12; k++) begin
        if (valid && ready) got++;
        tick();
      end
      check("drained_count", 64'(got), 64'd4);
    end

    // ---------------- redirect with full queue ----------------
    phase = "redirect_full";
    async_reset();
    rst   = 1'b1;
    ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("queue_full_valid", 64'(valid), 64'h1);
    redirect_en = 1'b1;
    redirect_pc = 64'h0B;
    tick();
    redirect_en = 1'b0;
    check("flush_valid", 64'(valid), 64'h0);
    ready = 1'b1;
    tick();
    check("redir_I",  64'(I), 64'h0063A023);
    check("redir_pc", pc_out, 64'h8);

    // ---------------- redirect out of HALT ----------------
    phase = "halt_redirect";
    for (int k = 0; k < 10 && !halted; k++) tick();
    check("halted_again", 64'(halted), 64'h1);
    redirect_en = 1'b1;
    redirect_pc = 64'h4;
    tick();
    redirect_en = 1'b0;
    check("unhalted", 64'(halted), 64'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("resume_I", 64'(I), 64'(prog[k]));
    end

    // ---------------- address wrap ----------------
    phase = "wrap";
    redirect_en = 1'b1;
    redirect_pc = 64'h100;
    tick();
    redirect_en = 1'b0;
    tick();
    check("wrap_I",  64'(I), 64'hFE532A23);
    check("wrap_pc", pc_out, 64'h100);

    // ---------------- load collides with fetch ----------------
    phase = "load_fetch";
    ready       = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 64'h40;
    tick();
    redirect_en = 1'b0;
    begin
      logic [31:0] old_w;
      old_w     = mem_m[16];
      load_en   = 1'b1;
      load_addr = AW'(16);
      load_data = 32'hCAFEF00D;
      tick();
      load_en = 1'b0;
      check("old_word_I", 64'(I), 64'(old_w));
      check("old_word_pc", pc_out, 64'h40);
    end
    redirect_en = 1'b1;
    tick();
    redirect_en = 1'b0;
    tick();
    check("new_word_I", 64'(I), 64'hCAFEF00D);

    // ---------------- randomized traffic ----------------
    phase = "random";
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) == 0) begin
        async_reset();
        rst = 1'b1;
      end
      ready       = ($urandom_range(9) < 7);
      redirect_en = ($urandom_range(19) == 0);
      redirect_pc = {$urandom(), $urandom()};
      load_en     = ($urandom_range(7) == 0);
      load_addr   = AW'($urandom_range(MW - 1));
      load_data   = ($urandom_range(5) == 0) ? 32'h0 : $urandom();
      tick();
    end
    idle_inputs();

    // ---------------- reset mid-stream ----------------
    phase = "mid_reset";
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      load_en   = 1'b1;
      load_addr = AW'(k);
      load_data = prog[k];
      tick();
    end
    idle_inputs();
    redirect_en = 1'b1;
    redirect_pc = 64'h0;
    tick();
    redirect_en = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    check("pre_reset_valid", 64'(valid), 64'h1);
    async_reset();
    check("post_reset_I", 64'(I), 64'h0);
    rst = 1'b1;
    tick();
    check("idle_cycle_valid", 64'(valid), 64'h0);
    tick();
    check("restart_I",  64'(I), 64'hFE532A23);
    check("restart_pc", pc_out, 64'h0);
    for (int k = 0; k < 6; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
